// File: rtl/steer_en_hyst.sv
// rtl/steer_en_hyst.sv - rider-detect / steering-enable controller with weight hysteresis
// Registered load-cell inputs feed a 3-state FSM with a saturating settle timer and step-off debounce.
module steer_en_hyst #(
  parameter int LD_W         = 12,
  parameter int TMR_W        = 26,
  parameter int SETTLE_CNT   = 65000000,
  parameter int MIN_WT       = 'h200,
  parameter int HYST         = 'h020,
  parameter int SETTLE_SHIFT = 2,
  parameter int OFF_SHIFT    = 4,
  parameter int OFF_DBNC     = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  output logic [LD_W-1:0] ld_cell_diff,
  output logic            en_steer,
  output logic            rider_off,
  output logic [1:0]      state_o
);

  // Comparison width holds sum*(2^OFF_SHIFT-1) and diff shifted by either amount.
  localparam int CMP_W = LD_W + 2 + OFF_SHIFT + SETTLE_SHIFT;
  localparam int DB_W  = $clog2(OFF_DBNC + 1);

  localparam logic [CMP_W-1:0] ON_TH   = CMP_W'(MIN_WT + HYST);
  localparam logic [CMP_W-1:0] OFF_TH  = CMP_W'(MIN_WT - HYST);
  localparam logic [CMP_W-1:0] OFF_MUL = CMP_W'((1 << OFF_SHIFT) - 1);
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(SETTLE_CNT);
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(OFF_DBNC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    STEER = 2'd2
  } state_t;

  state_t            state, nxt;
  logic [LD_W-1:0]   l_q, r_q;
  logic [LD_W:0]     sum;
  logic [LD_W-1:0]   diff;
  logic [CMP_W-1:0]  sum_c, diff_c;
  logic              on_wt, off_wt, settled, step_off;
  logic [TMR_W-1:0]  tmr;
  logic              tmr_full, clr_tmr;
  logic [DB_W-1:0]   dbnc, dbnc_inc;
  logic              dbnc_hit, off_pulse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_q <= '0;
      r_q <= '0;
    end else begin
      l_q <= lft_ld;
      r_q <= rght_ld;
    end
  end

  assign sum    = {1'b0, l_q} + {1'b0, r_q};
  assign diff   = (l_q >= r_q) ? (l_q - r_q) : (r_q - l_q);
  assign sum_c  = CMP_W'(sum);
  assign diff_c = CMP_W'(diff);

  assign on_wt    = (sum_c >= ON_TH);
  assign off_wt   = (sum_c < OFF_TH);
  assign settled  = ((diff_c << SETTLE_SHIFT) <= sum_c);
  assign step_off = ((diff_c << OFF_SHIFT) > (sum_c * OFF_MUL));

  assign tmr_full = (tmr == TMR_MAX);
  assign dbnc_inc = (dbnc == DB_MAX) ? dbnc : dbnc + 1'b1;
  // Count includes the current sample, so the OFF_DBNC-th step-off cycle triggers the exit.
  assign dbnc_hit = step_off && (dbnc_inc == DB_MAX);

  always_comb begin
    nxt       = state;
    clr_tmr   = 1'b0;
    off_pulse = 1'b0;
    if (!en) begin
      nxt     = IDLE;
      clr_tmr = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (on_wt) begin
            nxt     = WAIT;
            clr_tmr = 1'b1;
          end
        end
        WAIT: begin
          if (off_wt) begin
            nxt       = IDLE;
            off_pulse = 1'b1;
          end else if (!settled) begin
            clr_tmr = 1'b1;
          end else if (tmr_full) begin
            nxt = STEER;
          end
        end
        STEER: begin
          if (off_wt) begin
            nxt       = IDLE;
            off_pulse = 1'b1;
          end else if (dbnc_hit) begin
            nxt     = WAIT;
            clr_tmr = 1'b1;
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      tmr          <= '0;
      dbnc         <= '0;
      ld_cell_diff <= '0;
      en_steer     <= 1'b0;
      rider_off    <= 1'b0;
    end else begin
      state        <= nxt;
      ld_cell_diff <= diff;
      en_steer     <= (nxt == STEER);
      rider_off    <= off_pulse;
      if (clr_tmr)
        tmr <= '0;
      else if (!tmr_full)
        tmr <= tmr + 1'b1;
      if (!en || state != STEER || !step_off)
        dbnc <= '0;
      else
        dbnc <= dbnc_inc;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_steer_en_hyst.sv
// tb/tb_steer_en_hyst.sv - self-checking bench for steer_en_hyst
// Directed stimulus; a cycle model built on run-length counts is compared every cycle.
module tb_steer_en_hyst;

  localparam int LD_W       = 12;
  localparam int SETTLE_CNT = 100;
  localparam int OFF_DBNC   = 4;
  localparam int MIN_WT     = 'h200;
  localparam int HYST       = 'h020;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b1;
  logic [LD_W-1:0] lft_ld = '0;
  logic [LD_W-1:0] rght_ld = '0;
  logic [LD_W-1:0] ld_cell_diff;
  logic            en_steer;
  logic            rider_off;
  logic [1:0]      state_o;

  int checks = 0;
  int errors = 0;

  steer_en_hyst #(
    .SETTLE_CNT(SETTLE_CNT),
    .OFF_DBNC  (OFF_DBNC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .lft_ld      (lft_ld),
    .rght_ld     (rght_ld),
    .ld_cell_diff(ld_cell_diff),
    .en_steer    (en_steer),
    .rider_off   (rider_off),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: state 0/1/2, run = consecutive settled WAIT samples, streak = consecutive step-off STEER samples.
  int m_l, m_r, m_st, m_run, m_streak, m_diff;
  bit m_ro;
  int s, d, n_st, n_run, n_streak;
  bit onw, offw, sett, stp, n_ro;

  always_comb begin
    s        = m_l + m_r;
    d        = (m_l > m_r) ? (m_l - m_r) : (m_r - m_l);
    onw      = (s >= MIN_WT + HYST);
    offw     = (s < MIN_WT - HYST);
    sett     = (d * 4 <= s);
    stp      = (d * 16 > s * 15);
    n_st     = m_st;
    n_run    = m_run;
    n_streak = 0;
    n_ro     = 1'b0;
    if (!en) begin
      n_st  = 0;
      n_run = 0;
    end else if (m_st == 0) begin
      if (onw) begin
        n_st  = 1;
        n_run = 0;
      end
    end else if (m_st == 1) begin
      if (offw) begin
        n_st = 0;
        n_ro = 1'b1;
      end else if (!sett) begin
        n_run = 0;
      end else begin
        n_run = m_run + 1;
        if (n_run == SETTLE_CNT + 1) n_st = 2;
      end
    end else begin
      if (offw) begin
        n_st = 0;
        n_ro = 1'b1;
      end else if (stp) begin
        n_streak = m_streak + 1;
        if (n_streak == OFF_DBNC) begin
          n_st     = 1;
          n_run    = 0;
          n_streak = 0;
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_l <= 0; m_r <= 0; m_st <= 0; m_run <= 0; m_streak <= 0; m_diff <= 0; m_ro <= 1'b0;
    end else begin
      m_l      <= int'(lft_ld);
      m_r      <= int'(rght_ld);
      m_diff   <= d;
      m_st     <= n_st;
      m_run    <= n_run;
      m_streak <= n_streak;
      m_ro     <= n_ro;
    end
  end

  always @(negedge clk) begin
    chk("model_state", int'(state_o), m_st);
    chk("model_en_steer", int'(en_steer), (m_st == 2) ? 1 : 0);
    chk("model_rider_off", int'(rider_off), int'(m_ro));
    chk("model_diff", int'(ld_cell_diff), m_diff);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ld(input logic [LD_W-1:0] l, input logic [LD_W-1:0] r);
    lft_ld  = l;
    rght_ld = r;
  endtask

  initial begin
    // Reset with weight present
    set_ld(12'h300, 12'h300);
    cyc(3);
    chk("rst_state", int'(state_o), 0);
    chk("rst_en_steer", int'(en_steer), 0);
    chk("rst_rider_off", int'(rider_off), 0);
    chk("rst_diff", int'(ld_cell_diff), 0);
    rst_n = 1'b1;
    cyc(1);
    chk("rel_state_1", int'(state_o), 0);
    cyc(1);
    chk("rel_state_2", int'(state_o), 1);
    cyc(100);
    chk("wait_100_state", int'(state_o), 1);
    chk("wait_100_en", int'(en_steer), 0);
    cyc(1);
    chk("wait_101_state", int'(state_o), 2);
    chk("wait_101_en", int'(en_steer), 1);
    chk("bal_diff", int'(ld_cell_diff), 0);

    // Hysteresis
    set_ld(12'h000, 12'h000);
    cyc(2);
    chk("drop_state", int'(state_o), 0);
    chk("drop_pulse", int'(rider_off), 1);
    cyc(1);
    chk("drop_pulse_end", int'(rider_off), 0);
    set_ld(12'h108, 12'h108);
    cyc(5);
    chk("hyst_210_idle", int'(state_o), 0);
    set_ld(12'h110, 12'h110);
    cyc(2);
    chk("hyst_220_wait", int'(state_o), 1);
    set_ld(12'h0F8, 12'h0F8);
    cyc(5);
    chk("hyst_1f0_wait", int'(state_o), 1);
    set_ld(12'h0F0, 12'h0EF);
    cyc(2);
    chk("hyst_1df_idle", int'(state_o), 0);
    chk("hyst_1df_pulse", int'(rider_off), 1);
    chk("hyst_diff_1", int'(ld_cell_diff), 1);
    cyc(1);
    chk("hyst_pulse_end", int'(rider_off), 0);

    // Unsettled stance restarts the timer
    set_ld(12'h180, 12'h180);
    cyc(2);
    chk("unset_wait", int'(state_o), 1);
    set_ld(12'h200, 12'h0F0);
    cyc(50);
    chk("unset_diff", int'(ld_cell_diff), 'h110);
    chk("unset_still_wait", int'(state_o), 1);
    set_ld(12'h180, 12'h180);
    cyc(101);
    chk("unset_100_wait", int'(state_o), 1);
    cyc(1);
    chk("unset_101_steer", int'(state_o), 2);

    // Step-off debounce: 3 cycles not enough, 4 exits
    set_ld(12'h3F0, 12'h010);
    cyc(3);
    set_ld(12'h180, 12'h180);
    cyc(5);
    chk("dbnc3_steer", int'(state_o), 2);
    chk("dbnc3_en", int'(en_steer), 1);
    set_ld(12'h3F0, 12'h010);
    cyc(4);
    set_ld(12'h180, 12'h180);
    chk("dbnc4_pre", int'(state_o), 2);
    cyc(1);
    chk("dbnc4_wait", int'(state_o), 1);
    chk("dbnc4_en_fall", int'(en_steer), 0);
    chk("dbnc4_no_pulse", int'(rider_off), 0);
    cyc(101);
    chk("resteer", int'(state_o), 2);

    // off_wt wins over the debounce exit
    set_ld(12'h3F0, 12'h010);
    cyc(3);
    set_ld(12'h1D0, 12'h000);
    cyc(1);
    chk("sim_pre", int'(state_o), 2);
    cyc(1);
    chk("sim_idle", int'(state_o), 0);
    chk("sim_pulse", int'(rider_off), 1);
    chk("sim_en", int'(en_steer), 0);
    cyc(1);
    chk("sim_pulse_end", int'(rider_off), 0);

    // Global enable
    set_ld(12'h180, 12'h180);
    cyc(2);
    chk("en_wait", int'(state_o), 1);
    cyc(101);
    chk("en_steer_reached", int'(state_o), 2);
    en = 1'b0;
    cyc(1);
    chk("en_off_idle", int'(state_o), 0);
    chk("en_off_no_pulse", int'(rider_off), 0);
    chk("en_off_en", int'(en_steer), 0);
    cyc(4);
    chk("en_off_hold", int'(state_o), 0);
    en = 1'b1;
    cyc(1);
    chk("en_on_wait", int'(state_o), 1);

    // Asynchronous reset mid-operation
    cyc(5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", int'(state_o), 0);
    chk("arst_pulse", int'(rider_off), 0);
    chk("arst_diff", int'(ld_cell_diff), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    chk("arst_rewait", int'(state_o), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/steer_en_hyst.md
# steer_en_hyst

Parametrised rider-detect and steering-enable controller for the Segway balance path. It sits between the A2D interface (left/right load-cell readings) and balance_cntrl. It decides when a rider is on and settled, then asserts `en_steer`, and it flags rider dismount. Compared with the previous generation it adds:
- generic data and timer widths,
- weight hysteresis,
- exact ratio comparisons,
- a debounced step-off check,
- registered inputs and outputs,
- a saturating settle timer,
- a global enable.

## Interface
Parameters:
- `LD_W`, 12: load-cell sample width (unsigned).
- `TMR_W`, 26: settle-timer width.
- `SETTLE_CNT`, 65000000: cycles of continuous settled stance required before steering (1.3 s at 50 MHz). Range 1..2^TMR_W-1.
- `MIN_WT`, 'h200: nominal minimum rider weight (sum of both cells).
- `HYST`, 'h020: weight hysteresis. On-threshold is MIN_WT+HYST; off-threshold is MIN_WT-HYST. HYST < MIN_WT is required.
- `SETTLE_SHIFT`, 2: rider is settled when `diff <= sum/2^SETTLE_SHIFT`.
- `OFF_SHIFT`, 4: stepping off when `diff > sum*(2^OFF_SHIFT-1)/2^OFF_SHIFT`.
- `OFF_DBNC`, 4: consecutive step-off cycles required in STEER (≥1).

Ports:
- `clk`, input, 1: clock.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `en`, input, 1: block enable. Low forces IDLE.
- `lft_ld`, input, LD_W: left load cell, unsigned.
- `rght_ld`, input, LD_W: right load cell, unsigned.
- `ld_cell_diff`, output, LD_W: registered |lft-rght|.
- `en_steer`, output, 1: registered; high while in STEER.
- `rider_off`, output, 1: registered one-cycle pulse on dismount.
- `state_o`, output, 2: current state (IDLE=0, WAIT=1, STEER=2).

## Operation
- Stage 0: `lft_ld` and `rght_ld` are registered every cycle into `l_q` and `r_q`. All decisions use the registered values.
- `sum = l_q + r_q`, computed at LD_W+1 bits, no overflow.
- `diff = |l_q - r_q|`, computed exactly at LD_W bits. Its registered copy is driven on `ld_cell_diff`.
- Conditions:
  - `on_wt`: sum >= MIN_WT+HYST.
  - `off_wt`: sum < MIN_WT-HYST.
  - `settled`: (diff<<SETTLE_SHIFT) <= sum.
  - `step_off`: (diff<<OFF_SHIFT) > sum*(2^OFF_SHIFT-1).
  - All comparisons are evaluated at full width with no truncation.
- Settle timer:
  - Clears on `clr_tmr`.
  - Otherwise increments, saturating at SETTLE_CNT. It never wraps.
  - `tmr_full` = (tmr == SETTLE_CNT).
- Debounce counter:
  - Counts consecutive STEER cycles with `step_off` high, saturating at OFF_DBNC.
  - Clears when `step_off` is low or the state is not STEER.
- FSM (priority top-down within each state):
  - **Any state, `en`=0:** next state IDLE, counters cleared, no `rider_off` pulse.
  - **IDLE:**
    - `on_wt` → WAIT, clr_tmr.
    - Else stay.
  - **WAIT:**
    - `off_wt` → IDLE, pulse `rider_off`.
    - Else `!settled` → stay, clr_tmr.
    - Else `tmr_full` → STEER.
    - Else stay, timer runs.
  - **STEER:**
    - `off_wt` → IDLE, pulse `rider_off`.
    - Else debounce count reaches OFF_DBNC → WAIT, clr_tmr.
    - Else stay.
- Weight between the two thresholds causes no transition: IDLE stays IDLE, and WAIT/STEER do not drop.
- `off_wt` overrides `step_off` and timer expiry in the same cycle.

## Timing
- Reset values:
  - State IDLE.
  - `l_q`, `r_q`, timer and debounce counter all 0.
  - `ld_cell_diff`=0, `en_steer`=0, `rider_off`=0, `state_o`=0.
- Reset mid-operation returns to IDLE asynchronously. `rider_off` is not pulsed.
- Input-to-decision latency: a sample on cycle N is registered at edge N+1, and the state changes at edge N+2.
- `en_steer`, `rider_off` and `state_o` are registered from the next state and change on the same edge as the state.
- `en_steer` rises on the edge the FSM enters STEER and falls on the edge it leaves.
- `rider_off` is high for exactly one cycle, coincident with the first IDLE cycle.
- `ld_cell_diff` lags `lft_ld`/`rght_ld` by 2 cycles.
- WAIT→STEER: the first settled WAIT cycle has timer=0. STEER is entered SETTLE_CNT+1 cycles after the timer last cleared.
- STEER→WAIT: occurs OFF_DBNC consecutive `step_off` cycles after the first one is registered.

## Test plan
Bench parameters: SETTLE_CNT=100, OFF_DBNC=4, defaults otherwise.

1. **Reset.** Assert reset with inputs 'h300/'h300, then release. → All outputs are 0. `state_o` becomes 1 two cycles after release. `en_steer` rises 101 cycles after WAIT entry. `ld_cell_diff`=0.
2. **Hysteresis.** Drive sum='h210, i.e. l='h108, r='h108. → Stays in IDLE. Raise to 'h220 → enters WAIT. Lower to 'h1F0 → stays in WAIT. Lower to 'h1DF → goes to IDLE and `rider_off` pulses once.
3. **Unsettled.** In WAIT, l='h200, r='h0F0 (diff 'h110 > sum/4 'hBC) for 50 cycles, then balanced. → The timer restarts and STEER is reached 101 cycles after balance is registered.
4. **Step-off debounce.** In STEER, l='h3F0, r='h010 (diff 'h3E0 > 15/16 of 'h400 = 'h3C0):
   - Held for 3 cycles, then cleared → remains in STEER.
   - Held for 4 cycles → goes to WAIT and `en_steer` falls.
5. **Simultaneous events.** In STEER, debounce count is 3 and the next sample has sum < 'h1E0. → Goes to IDLE, not WAIT, and `rider_off` pulses once.
6. **Enable.** In STEER, drop `en`. → IDLE on the next edge with no `rider_off` pulse. Raise `en` with weight present → WAIT.
